// File: rtl/seq_mul_shift_add_pkg.sv
// Shared types and constants for the shift-and-add sequential multiplier.
// Holds the default width, the controller state encoding and the counter sizing helper.
package seq_mul_shift_add_pkg;

  localparam int MUL_N = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_mul_shift_add_add.sv
// Purely combinational 2N-bit adder; the carry out of the top bit is dropped.
module add_2n #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/seq_mul_shift_add.sv
// Sequential unsigned NxN -> 2N multiplier, retiring one multiplier bit per clock.
// A single shared adder accumulates the shifted multiplicand while the FSM walks the bits.
module seq_mul_shift_add
  import seq_mul_shift_add_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           busy,
  output logic [2*N-1:0] result
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_e          state_q;
  logic [2*N-1:0]  mcand_q;
  logic [N-1:0]    mplier_q;
  logic [2*N-1:0]  acc_q;
  logic [CW-1:0]   cnt_q;
  logic [2*N-1:0]  sum;
  logic [2*N-1:0]  acc_d;

  add_2n #(.W(2 * N)) u_add (
    .a   (acc_q),
    .b   (mcand_q),
    .sum (sum)
  );

  // The adder output is only taken when the current multiplier bit is set.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      result   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{N{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[2*N-2:0], 1'b0};
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Last multiplier bit: publish the finished product in the same edge.
          if (cnt_q == LAST_CNT) begin
            result  <= acc_d;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Directed self-checking bench for seq_mul_shift_add (N=8) with hand-computed products.
// Observes outputs on the falling edge, away from the active rising edge.
module tb_seq_mul_shift_add;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        busy;
  logic [15:0] result;

  int passCount = 0;
  int checkCount = 0;
  logic [15:0] prevResult = '0;

  seq_mul_shift_add #(.N(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_i    (a_i),
    .b_i    (b_i),
    .busy   (busy),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // mode 0: plain op; mode 1: extra start pulse mid-run; mode 2: operands change mid-run
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expProduct, input int mode);
    int width;
    @(negedge clk);
    a_i = a;
    b_i = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    width = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      width++;
      if (k == 0) checkOutput({tag, "_hold"}, result, prevResult);
      if (mode == 1 && k == 2) begin
        start = 1'b1;
        a_i = 8'd9;
        b_i = 8'd9;
      end
      if (mode == 1 && k == 3) start = 1'b0;
      if (mode == 2 && k == 2) begin
        a_i = 8'd1;
        b_i = 8'd1;
      end
    end
    checkOutput({tag, "_busywidth"}, width, 8);
    checkOutput({tag, "_result"}, result, expProduct);
    prevResult = expProduct;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    prevResult = '0;
  endtask

  initial begin
    int waitCnt;
    rst = 1'b0;
    start = 1'b0;
    a_i = '0;
    b_i = '0;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_result", result, 0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus("mul3x2", 8'd3, 8'd2, 16'd6, 0);
    applyReset();
    checkOutput("reset2_result", result, 0);
    applyStimulus("mul5x5", 8'd5, 8'd5, 16'd25, 0);
    applyReset();
    applyStimulus("mul4x3", 8'd4, 8'd3, 16'd12, 0);

    applyStimulus("mul255x255", 8'd255, 8'd255, 16'd65025, 0);
    applyStimulus("mul0x77", 8'd0, 8'd77, 16'd0, 0);
    applyStimulus("mul1x200", 8'd1, 8'd200, 16'd200, 0);

    // start held high: one idle cycle, then the next op is accepted with fresh operands
    @(negedge clk);
    a_i = 8'd2;
    b_i = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1 a_i = 8'd4;
    waitCnt = 0;
    do begin
      @(negedge clk);
      waitCnt++;
    end while (busy && waitCnt < 40);
    checkOutput("held_first_busy", busy, 0);
    checkOutput("held_first_result", result, 6);
    @(negedge clk);
    checkOutput("held_reaccept_busy", busy, 1);
    start = 1'b0;
    waitCnt = 0;
    do begin
      @(negedge clk);
      waitCnt++;
    end while (busy && waitCnt < 40);
    checkOutput("held_second_busy", busy, 0);
    checkOutput("held_second_result", result, 12);
    prevResult = 16'd12;

    applyStimulus("mul7x6_pulse", 8'd7, 8'd6, 16'd42, 1);
    checkOutput("pulse_idle_after", busy, 0);
    applyStimulus("mul13x10_chg", 8'd13, 8'd10, 16'd130, 2);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    a_i = 8'd15;
    b_i = 8'd15;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrun_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_result", result, 0);
    @(negedge clk);
    rst = 1'b1;
    prevResult = '0;
    applyStimulus("mul12x11", 8'd12, 8'd11, 16'd132, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
